// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - stored-program feeder driving processor IN_DATA_BUS and step clock
module program_sequencer #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int HIGH_CYC = 4,
  parameter int LOW_CYC  = 4
) (
  input  logic          CLK50MHz,
  input  logic          RST,
  input  logic          CLEAR,
  input  logic          LOAD_WE,
  input  logic [9:0]    LOAD_DATA,
  input  logic          RUN,
  input  logic          EXT_IN,
  input  logic          DONE_IN,
  output logic [9:0]    PROG_DATA,
  output logic          STEP_CLKb,
  output logic [AW:0]   PC,
  output logic [AW:0]   LEN,
  output logic          BUSY,
  output logic          HALT,
  output logic          ERR,
  output logic          OVF,
  output logic [7:0]    STEPS
);

  localparam int MAXC = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_PULSE, S_EVAL, S_HALT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [AW:0]   pc_nxt, len_nxt;
  logic          err_nxt, ovf_nxt;
  logic [7:0]    steps_nxt;
  logic          ext_l, done_l, ext_nxt, done_nxt;
  logic          mem_we;
  logic [9:0]    data_nxt;
  logic [9:0]    mem [0:DEPTH-1];

  assign BUSY = (state == S_SETUP) || (state == S_PULSE) || (state == S_EVAL);
  assign HALT = (state == S_HALT);

  // Next-state, program bookkeeping and load handling
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pc_nxt    = PC;
    len_nxt   = LEN;
    err_nxt   = ERR;
    ovf_nxt   = OVF;
    steps_nxt = STEPS;
    ext_nxt   = ext_l;
    done_nxt  = done_l;
    mem_we    = 1'b0;
    case (state)
      S_IDLE, S_HALT: begin
        if (CLEAR) begin
          len_nxt = '0;
          ovf_nxt = 1'b0;
        end else if (LOAD_WE) begin
          if (LEN == DEPTH_V) begin
            ovf_nxt = 1'b1;
          end else begin
            mem_we  = 1'b1;
            len_nxt = LEN + 1'b1;
          end
        end
        // Start only if there is something to feed after this cycle's clear/load
        if (RUN && (len_nxt != '0)) begin
          pc_nxt    = '0;
          steps_nxt = '0;
          err_nxt   = 1'b0;
          cnt_nxt   = '0;
          state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt == CW'(HIGH_CYC - 1)) begin
          cnt_nxt   = '0;
          state_nxt = S_PULSE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_PULSE: begin
        if (cnt == CW'(LOW_CYC - 1)) begin
          cnt_nxt   = '0;
          ext_nxt   = EXT_IN;
          done_nxt  = DONE_IN;
          state_nxt = S_EVAL;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_EVAL: begin
        if (STEPS != 8'hFF) steps_nxt = STEPS + 8'd1;
        if (ext_l && (PC == LEN)) begin
          err_nxt   = 1'b1;
          state_nxt = S_HALT;
        end else begin
          if (ext_l) pc_nxt = PC + 1'b1;
          state_nxt = (done_l && (pc_nxt == LEN)) ? S_HALT : S_SETUP;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bus word follows the next PC so it is settled before SETUP begins; bypass a same-cycle write
  always_comb begin
    data_nxt = 10'd0;
    if (pc_nxt < len_nxt) begin
      if (mem_we && (pc_nxt == LEN)) data_nxt = LOAD_DATA;
      else                           data_nxt = mem[pc_nxt[AW-1:0]];
    end
  end

  // State and output registers; reset forces the step clock high at once
  always_ff @(posedge CLK50MHz or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      cnt       <= '0;
      PC        <= '0;
      LEN       <= '0;
      ERR       <= 1'b0;
      OVF       <= 1'b0;
      STEPS     <= '0;
      ext_l     <= 1'b0;
      done_l    <= 1'b0;
      PROG_DATA <= '0;
      STEP_CLKb <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      PC        <= pc_nxt;
      LEN       <= len_nxt;
      ERR       <= err_nxt;
      OVF       <= ovf_nxt;
      STEPS     <= steps_nxt;
      ext_l     <= ext_nxt;
      done_l    <= done_nxt;
      PROG_DATA <= data_nxt;
      STEP_CLKb <= (state_nxt != S_PULSE);
    end
  end

  // Program store, written only while stopped and never cleared
  always_ff @(posedge CLK50MHz) begin
    if (mem_we) mem[LEN[AW-1:0]] <= LOAD_DATA;
  end

endmodule
